bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
- Downstream consumer of the committed BCD operand (three digits plus sign) from the digit-entry stage.
- Converts a signed 3-digit BCD value (-999..+999) into a two's-complement binary word for the arithmetic stage.
- Iterative multiply-by-ten-and-add datapath with a start/valid handshake, a busy flag and an invalid-digit flag.

Parameters:
OUT_W, 11, result width in bits; legal range is OUT_W >= 11, which is needed to hold ±999.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request conversion; sampled only in IDLE.
huns_in  input  4  hundreds BCD digit.
tens_in  input  4  tens BCD digit.
ones_in  input  4  ones BCD digit.
sign_in  input  1  1 = negative operand.
busy  output  1  high while a conversion is in progress (any state other than IDLE).
valid  output  1  single-cycle pulse when result and err are updated.
result  output  OUT_W  signed two's-complement value; held between conversions.
err  output  1  set if any latched digit was > 9; held with result.

Behaviour:
- Reset (async, any state): state = IDLE, accumulator = 0, digit index = 0, latched digits and sign = 0, busy = 0, valid = 0, result = 0, err = 0.
- States: IDLE, ACCUM, SIGN.
- IDLE:
  - On posedge with start = 1: latch huns_in, tens_in, ones_in and sign_in.
  - Clear the accumulator, set the digit index to 0 (hundreds) and go to ACCUM.
  - Set busy = 1 on the same edge.
  - The latched copy is used from then on; input changes after the start edge are ignored.
- ACCUM: one digit per cycle, in order hundreds, tens, ones.
  - Update: acc <= (acc << 3) + (acc << 1) + digit. No multiplier.
  - Any digit > 9 sets an internal error flag; accumulation continues regardless.
  - After the ones digit, go to SIGN.
  - Accumulator width: 10 bits unsigned (max 999). Inputs above 9 may exceed this; the overflow is truncated, which is irrelevant because err forces result to 0.
- SIGN (one cycle):
  - Error flag set: result <= 0, err <= 1.
  - Otherwise: result <= sign ? -acc : +acc, sign-extended to OUT_W; err <= 0.
  - On the same edge: valid <= 1, busy <= 0, state <= IDLE.
- valid is high for exactly one cycle and clears on the next edge.
- Latency: start sampled on edge N gives valid high after edge N+4, with result stable from the same edge.
- start while busy = 1 is ignored; it is neither queued nor restarts the conversion.
- start held high continuously: a new conversion begins on the edge after valid returns to IDLE. Throughput is one conversion per 5 cycles.
- Negative zero (sign = 1, digits 0,0,0): result = 0; there is no -0 encoding.
- Reset mid-conversion: aborts immediately. No valid pulse is produced, and result and err return to 0.
- result and err change only on the SIGN-state edge or on reset.

Test Plan:
1. Reset, then start with sign=0 and digits 1,2,3 → valid pulses exactly 4 edges after start is sampled; result = 123 (0x07B); err = 0; busy high for 4 cycles.
2. start with sign=1 and digits 9,9,9 → result = -999 (11'h419); err = 0. Then start with sign=1 and digits 0,0,0 → result = 0.
3. start with sign=0 and digits 0,12,5 → valid pulses; result = 0; err = 1. A following valid conversion of 0,0,7 → result = 7; err = 0.
4. Pulse start again 2 cycles into a busy conversion of 4,5,6 and change the digit inputs → one valid only; result = 456; no second conversion.
5. Hold start = 1 constantly with digits 0,0,1 → valid pulses every 5 cycles; result stays 1.
6. Assert rst 2 cycles after start (digits 8,8,8) → busy, valid, result and err go to 0 immediately with no valid pulse; a subsequent start converts normally.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle between the digit-entry stage and the BCD-to-binary converter.
interface bcd_to_bin_if #(
  parameter int OUT_W = 11
);
  logic             start;
  logic [3:0]       huns_in;
  logic [3:0]       tens_in;
  logic [3:0]       ones_in;
  logic             sign_in;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] result;
  logic             err;

  modport master (
    output start, huns_in, tens_in, ones_in, sign_in,
    input  busy, valid, result, err
  );

  modport slave (
    input  start, huns_in, tens_in, ones_in, sign_in,
    output busy, valid, result, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Signed 3-digit BCD to two's-complement converter, one digit per cycle via acc*10 + digit.
// state | meaning
// IDLE  | waiting for start; operand latched on the start edge
// ACCUM | folding in hundreds, tens, ones (one per cycle)
// SIGN  | apply sign or force error result, pulse valid
module bcd_to_bin #(
  parameter int OUT_W = 11
) (
  input  logic          clk,
  input  logic          rst,
  bcd_to_bin_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SIGN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       acc_q, acc_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       huns_q, huns_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             sign_q, sign_d;
  logic             err_flag_q, err_flag_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [3:0]       digit;
  logic [9:0]       acc_next;
  logic [OUT_W-1:0] mag;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    huns_d     = huns_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    sign_d     = sign_q;
    err_flag_d = err_flag_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    err_d      = err_q;

    case (idx_q)
      2'd0:    digit = huns_q;
      2'd1:    digit = tens_q;
      default: digit = ones_q;
    endcase

    // acc*10 as (acc<<3)+(acc<<1); out-of-range digits may wrap, err masks the result anyway
    acc_next = {acc_q[6:0], 3'b000} + {acc_q[8:0], 1'b0} + {6'd0, digit};
    mag      = {{(OUT_W-10){1'b0}}, acc_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          huns_d     = bus.huns_in;
          tens_d     = bus.tens_in;
          ones_d     = bus.ones_in;
          sign_d     = bus.sign_in;
          acc_d      = 10'd0;
          idx_d      = 2'd0;
          err_flag_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_next;
        if (digit > 4'd9) err_flag_d = 1'b1;
        if (idx_q == 2'd2) state_d = SIGN;
        else               idx_d   = idx_q + 2'd1;
      end
      SIGN: begin
        if (err_flag_q) begin
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          result_d = sign_q ? -mag : mag;
          err_d    = 1'b0;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      huns_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      sign_q     <= 1'b0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      huns_q     <= huns_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      sign_q     <= sign_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed table, multi-cycle corner sequences, randomized vs. arithmetic model.
module tb_bcd_to_bin;
  localparam int OUT_W = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_to_bin_if #(.OUT_W(OUT_W)) bus ();

  bcd_to_bin #(.OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]       h;
    logic [3:0]       t;
    logic [3:0]       o;
    logic             s;
    logic [OUT_W-1:0] exp_res;
    logic             exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: value = 100h + 10t + o, negated if sign, zeroed with err on any bad digit
  function automatic void ref_model(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                                    input logic s, output logic [OUT_W-1:0] r, output logic e);
    int v;
    e = (h > 9) || (t > 9) || (o > 9);
    v = 100 * int'(h) + 10 * int'(t) + int'(o);
    if (e)      v = 0;
    else if (s) v = -v;
    r = OUT_W'(v);
  endfunction

  // Pulse start for one edge, then wait (bounded) for valid.
  task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input logic s, output int lat, output int busy_cycles);
    bus.huns_in = h;
    bus.tens_in = t;
    bus.ones_in = o;
    bus.sign_in = s;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    lat = 0;
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.valid) break;
      if (bus.busy) busy_cycles++;
      tick();
      lat++;
    end
  endtask

  task automatic finish_conv(input string name, input logic [OUT_W-1:0] exp_res, input logic exp_err,
                             input int lat, input int busy_cycles);
    check({name, " latency"}, lat, 4);
    check({name, " busy_cycles"}, busy_cycles, 4);
    check({name, " result"}, bus.result, exp_res);
    check({name, " err"}, bus.err, exp_err);
    check({name, " busy_at_valid"}, bus.busy, 1'b0);
    tick();
    check({name, " valid_one_cycle"}, bus.valid, 1'b0);
    check({name, " result_held"}, bus.result, exp_res);
  endtask

  initial begin
    int lat, bc, npulse, last_k;
    logic [OUT_W-1:0] er;
    logic ee;
    logic [3:0] rh, rt, ro;
    logic rs;

    vecs[0] = '{h: 4'd1, t: 4'd2,  o: 4'd3, s: 1'b0, exp_res: 11'h07B, exp_err: 1'b0};
    vecs[1] = '{h: 4'd9, t: 4'd9,  o: 4'd9, s: 1'b1, exp_res: 11'h419, exp_err: 1'b0};
    vecs[2] = '{h: 4'd0, t: 4'd0,  o: 4'd0, s: 1'b1, exp_res: 11'h000, exp_err: 1'b0};
    vecs[3] = '{h: 4'd0, t: 4'd12, o: 4'd5, s: 1'b0, exp_res: 11'h000, exp_err: 1'b1};
    vecs[4] = '{h: 4'd0, t: 4'd0,  o: 4'd7, s: 1'b0, exp_res: 11'h007, exp_err: 1'b0};

    rst = 1'b0;
    bus.start = 1'b0;
    bus.huns_in = '0;
    bus.tens_in = '0;
    bus.ones_in = '0;
    bus.sign_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset busy", bus.busy, 1'b0);
    check("reset valid", bus.valid, 1'b0);
    check("reset result", bus.result, '0);
    check("reset err", bus.err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_conv(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].s, lat, bc);
      finish_conv($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_err, lat, bc);
    end

    // start pulsed again mid-conversion with different digits must be ignored
    bus.huns_in = 4'd4; bus.tens_in = 4'd5; bus.ones_in = 4'd6; bus.sign_in = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.huns_in = 4'd7; bus.tens_in = 4'd8; bus.ones_in = 4'd9; bus.sign_in = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("busy_start valid", bus.valid, 1'b1);
    check("busy_start result", bus.result, 11'd456);
    npulse = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.valid) npulse++;
    end
    check("busy_start no_second_valid", npulse, 0);
    check("busy_start result_held", bus.result, 11'd456);

    // start held high: one conversion per 5 cycles
    bus.huns_in = 4'd0; bus.tens_in = 4'd0; bus.ones_in = 4'd1; bus.sign_in = 1'b0;
    bus.start = 1'b1;
    npulse = 0;
    last_k = -1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.valid) begin
        npulse++;
        if (last_k >= 0) check($sformatf("held_start interval@%0d", k), k - last_k, 5);
        else             check("held_start first_latency", k, 4);
        check($sformatf("held_start result@%0d", k), bus.result, 11'd1);
        last_k = k;
      end
    end
    bus.start = 1'b0;
    check("held_start pulses", npulse, 5);
    tick();
    tick();
    tick();
    tick();
    tick();

    // reset in the middle of a conversion
    bus.huns_in = 4'd8; bus.tens_in = 4'd8; bus.ones_in = 4'd8; bus.sign_in = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midreset busy", bus.busy, 1'b0);
    check("midreset valid", bus.valid, 1'b0);
    check("midreset result", bus.result, '0);
    check("midreset err", bus.err, 1'b0);
    tick();
    rst = 1'b0;
    npulse = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.valid) npulse++;
    end
    check("midreset no_valid", npulse, 0);
    run_conv(4'd8, 4'd8, 4'd8, 1'b0, lat, bc);
    finish_conv("after_reset", 11'd888, 1'b0, lat, bc);

    // randomized operands against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      rh = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rt = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      ro = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rs = 1'($urandom_range(0, 1));
      ref_model(rh, rt, ro, rs, er, ee);
      run_conv(rh, rt, ro, rs, lat, bc);
      finish_conv($sformatf("rand%0d %0d%0d%0d s%0d", n, rh, rt, ro, rs), er, ee, lat, bc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
